// File: rtl/insn_fetch_queue.sv
// rtl/insn_fetch_queue.sv - circular instruction fetch queue between fetch and decode
module insn_fetch_queue #(
    parameter int LG_DEPTH  = 3,
    parameter int M_WIDTH   = 32,
    parameter int LG_PHT_SZ = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [31:0]          enq_insn,
    input  logic [M_WIDTH-1:0]   enq_pc,
    input  logic                 enq_pred,
    input  logic [LG_PHT_SZ-1:0] enq_pht_idx,
    input  logic [M_WIDTH-1:0]   enq_pred_target,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [31:0]          deq_insn,
    output logic [M_WIDTH-1:0]   deq_pc,
    output logic                 deq_pred,
    output logic [LG_PHT_SZ-1:0] deq_pht_idx,
    output logic [M_WIDTH-1:0]   deq_pred_target,
    output logic [LG_DEPTH:0]    occupancy
);
    localparam int DEPTH = 1 << LG_DEPTH;
    localparam int PTR_W = LG_DEPTH + 1;

    logic [31:0]          insn_mem   [DEPTH];
    logic [M_WIDTH-1:0]   pc_mem     [DEPTH];
    logic                 pred_mem   [DEPTH];
    logic [LG_PHT_SZ-1:0] pht_mem    [DEPTH];
    logic [M_WIDTH-1:0]   target_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_nxt;
    logic [PTR_W-1:0] tail_nxt;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;

    // The wrap bit distinguishes full from empty when the index bits match.
    assign empty = (head == tail);
    assign full  = (head[LG_DEPTH-1:0] == tail[LG_DEPTH-1:0]) &&
                   (head[LG_DEPTH] != tail[LG_DEPTH]);

    assign enq_ready = !full;
    assign deq_valid = !empty;

    assign enq_fire = reset && enq_valid && enq_ready && !flush;
    assign deq_fire = reset && deq_valid && deq_ready && !flush;

    assign head_nxt = deq_fire ? head + PTR_W'(1) : head;
    assign tail_nxt = enq_fire ? tail + PTR_W'(1) : tail;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            occupancy <= tail_nxt - head_nxt;
        end
    end

    // Storage is never cleared; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            insn_mem[tail[LG_DEPTH-1:0]]   <= enq_insn;
            pc_mem[tail[LG_DEPTH-1:0]]     <= enq_pc;
            pred_mem[tail[LG_DEPTH-1:0]]   <= enq_pred;
            pht_mem[tail[LG_DEPTH-1:0]]    <= enq_pht_idx;
            target_mem[tail[LG_DEPTH-1:0]] <= enq_pred_target;
        end
    end

    assign deq_insn        = insn_mem[head[LG_DEPTH-1:0]];
    assign deq_pc          = pc_mem[head[LG_DEPTH-1:0]];
    assign deq_pred        = pred_mem[head[LG_DEPTH-1:0]];
    assign deq_pht_idx     = pht_mem[head[LG_DEPTH-1:0]];
    assign deq_pred_target = target_mem[head[LG_DEPTH-1:0]];
endmodule

// File: tb/tb_insn_fetch_queue.sv
// tb/tb_insn_fetch_queue.sv - directed self-checking bench for insn_fetch_queue
module tb_insn_fetch_queue;
    logic        clk = 0;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_insn;
    logic [31:0] enq_pc;
    logic        enq_pred;
    logic [15:0] enq_pht_idx;
    logic [31:0] enq_pred_target;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_insn;
    logic [31:0] deq_pc;
    logic        deq_pred;
    logic [15:0] deq_pht_idx;
    logic [31:0] deq_pred_target;
    logic [3:0]  occupancy;

    int errors = 0;
    int checks = 0;

    insn_fetch_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_insn(enq_insn),
        .enq_pc(enq_pc), .enq_pred(enq_pred), .enq_pht_idx(enq_pht_idx),
        .enq_pred_target(enq_pred_target),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_insn(deq_insn),
        .deq_pc(deq_pc), .deq_pred(deq_pred), .deq_pht_idx(deq_pht_idx),
        .deq_pred_target(deq_pred_target), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if (!(occupancy <= 4'd8)) begin
                errors++;
                $display("FAIL occ_bound: occupancy=%0d required <= 8", occupancy);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enq(input logic [31:0] pc);
        enq_valid       = 1'b1;
        enq_pc          = pc;
        enq_insn        = pc ^ 32'hA5A5_0013;
        enq_pred        = pc[2];
        enq_pht_idx     = pc[17:2];
        enq_pred_target = pc + 32'h100;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            set_enq(base + 32'(4 * i));
            step();
        end
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_insn = '0; enq_pc = '0; enq_pred = 1'b0; enq_pht_idx = '0; enq_pred_target = '0;
        step(); step();
        reset = 1'b1;
        step();
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_pass_through();
        enq_valid = 1'b1; enq_insn = 32'h0050_0093; enq_pc = 32'h1000; enq_pred = 1'b0;
        enq_pht_idx = 16'h0042; enq_pred_target = 32'h0000_1234;
        step();
        enq_valid = 1'b0;
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL pt_valid: got %b want 1", deq_valid); end
        checks++; if (deq_insn !== 32'h0050_0093) begin errors++; $display("FAIL pt_insn: got %h want 00500093", deq_insn); end
        checks++; if (deq_pc !== 32'h1000) begin errors++; $display("FAIL pt_pc: got %h want 00001000", deq_pc); end
        checks++; if (deq_pred !== 1'b0) begin errors++; $display("FAIL pt_pred: got %b want 0", deq_pred); end
        checks++; if (deq_pht_idx !== 16'h0042) begin errors++; $display("FAIL pt_pht: got %h want 0042", deq_pht_idx); end
        checks++; if (deq_pred_target !== 32'h1234) begin errors++; $display("FAIL pt_target: got %h want 00001234", deq_pred_target); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL pt_occ: got %0d want 1", occupancy); end
        step();
        checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL pt_hold: got %b want 1", deq_valid); end
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL pt_empty: got %b want 0", deq_valid); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL pt_occ_empty: got %0d want 0", occupancy); end
    endtask

    task automatic test_fill_full();
        fill(32'h2000, 8);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d want 8", occupancy); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", enq_ready); end
        set_enq(32'h2020);
        step();
        enq_valid = 1'b0;
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_drop_occ: got %0d want 8", occupancy); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b want 1", i, deq_valid); end
            checks++;
            if (deq_pc !== 32'h2000 + 32'(4 * i)) begin
                errors++; $display("FAIL drain_pc[%0d]: got %h want %h", i, deq_pc, 32'h2000 + 32'(4 * i));
            end
            checks++;
            if (deq_insn !== ((32'h2000 + 32'(4 * i)) ^ 32'hA5A5_0013)) begin
                errors++; $display("FAIL drain_insn[%0d]: got %h", i, deq_insn);
            end
            // Full-queue dequeue must not open a slot in the same cycle.
            if (i == 0) begin
                set_enq(32'h2024);
                deq_ready = 1'b1;
                step();
                enq_valid = 1'b0;
                checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_deq_enq_occ: got %0d want 7", occupancy); end
            end else begin
                deq_ready = 1'b1;
                step();
            end
        end
        deq_ready = 1'b0;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", deq_valid); end
    endtask

    task automatic test_wrap_concurrent();
        fill(32'h4000, 3);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (deq_pc !== 32'h4000 + 32'(4 * c) || deq_valid !== 1'b1) begin
                errors++; $display("FAIL wrap_pc[%0d]: got %h valid %b want %h", c, deq_pc, deq_valid, 32'h4000 + 32'(4 * c));
            end
            set_enq(32'h4000 + 32'(4 * (c + 3)));
            deq_ready = 1'b1;
            step();
            checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL wrap_occ[%0d]: got %0d want 3", c, occupancy); end
        end
        enq_valid = 1'b0;
        for (int c = 20; c < 23; c++) begin
            checks++;
            if (deq_pc !== 32'h4000 + 32'(4 * c) || deq_pred_target !== 32'h4100 + 32'(4 * c)) begin
                errors++; $display("FAIL wrap_tail_pc[%0d]: got %h want %h", c, deq_pc, 32'h4000 + 32'(4 * c));
            end
            step();
        end
        deq_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL wrap_end_occ: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        fill(32'h5000, 5);
        set_enq(32'h5555_0000);
        deq_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", enq_ready); end
        set_enq(32'h3000);
        step();
        enq_valid = 1'b0;
        checks++; if (deq_pc !== 32'h3000 || deq_valid !== 1'b1) begin errors++; $display("FAIL flush_next_pc: got %h valid %b want 00003000", deq_pc, deq_valid); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL flush_next_occ: got %0d want 1", occupancy); end
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        fill(32'h6000, 6);
        checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL rmid_pre_occ: got %0d want 6", occupancy); end
        set_enq(32'h6666_0000);
        reset = 1'b0;
        step();
        reset = 1'b1; enq_valid = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rmid_occ: got %0d want 0", occupancy); end
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", deq_valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", enq_ready); end
        set_enq(32'h7000);
        step();
        enq_valid = 1'b0;
        checks++; if (deq_pc !== 32'h7000) begin errors++; $display("FAIL rmid_next_pc: got %h want 00007000", deq_pc); end
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_stale: got %b want 0", deq_valid); end
    endtask

    task automatic test_back_to_back_empty();
        set_enq(32'h8000);
        deq_ready = 1'b1;
        step();
        enq_valid = 1'b0; deq_ready = 1'b0;
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL empty_both_occ: got %0d want 1", occupancy); end
        checks++; if (deq_pc !== 32'h8000 || deq_pht_idx !== 16'h2000) begin errors++; $display("FAIL empty_both_pc: got %h/%h want 00008000/2000", deq_pc, deq_pht_idx); end
        deq_ready = 1'b1;
        step(); step();
        deq_ready = 1'b0;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL idle_deq_occ: got %0d want 0", occupancy); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_fill_full();
        test_wrap_concurrent();
        test_flush();
        test_reset_mid();
        test_back_to_back_empty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
